// File: rtl/qdrc_pkg.sv
// Shared constants and types for the QDR controller read path.
// Holds default widths and the latency budget that sets the default READ_LATENCY.
package qdrc_pkg;

  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_TAG_WIDTH  = 4;

  // Latency components, in controller clock cycles.
  localparam int LAT_SYNC     = 2;
  localparam int LAT_OUTREG   = 1;
  localparam int LAT_OBUF     = 1;
  localparam int LAT_CHIP     = 2;
  localparam int LAT_IBUF     = 1;
  localparam int LAT_HALF_OFS = 1;
  localparam int LAT_WORD_OFS = 2;

  localparam int DEF_READ_LATENCY = LAT_SYNC + LAT_OUTREG + LAT_OBUF + LAT_CHIP +
                                    LAT_IBUF + LAT_HALF_OFS + LAT_WORD_OFS;

  // Source of the entry pushed into the delay line in a given cycle.
  typedef enum logic [1:0] {
    INS_NONE   = 2'd0,
    INS_ACCEPT = 2'd1,
    INS_BURST  = 2'd2
  } ins_sel_e;

  // Width of a down-counter that must hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qdrc_rd_pipe_if.sv
// User read port and PHY read-side signals of the QDR read-return path.
// The slave modport is the read pipe; the master modport is the user/PHY side.
interface qdrc_rd_pipe_if
  import qdrc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int PEND_WIDTH = 6
);

  logic                    phy_rdy;
  logic                    usr_strb;
  logic [TAG_WIDTH-1:0]    usr_tag;
  logic                    usr_rdy;
  logic [2*DATA_WIDTH-1:0] usr_data;
  logic                    usr_dvld;
  logic [TAG_WIDTH-1:0]    usr_dtag;
  logic                    usr_dlast;
  logic [PEND_WIDTH-1:0]   rd_pending;
  logic                    phy_strb;
  logic [2*DATA_WIDTH-1:0] phy_data;

  modport master (
    output phy_rdy, usr_strb, usr_tag, phy_data,
    input  usr_rdy, usr_data, usr_dvld, usr_dtag, usr_dlast, rd_pending, phy_strb
  );

  modport slave (
    input  phy_rdy, usr_strb, usr_tag, phy_data,
    output usr_rdy, usr_data, usr_dvld, usr_dtag, usr_dlast, rd_pending, phy_strb
  );

endinterface

// File: rtl/qdrc_rd_delay.sv
// Fixed-depth shift register of {vld, tag, last} tracking reads in flight to the PHY.
// Shifts every cycle; the tail marks the cycle the PHY returns the matching beat.
module qdrc_rd_delay #(
  parameter int TAG_WIDTH = 4,
  parameter int DEPTH     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_vld,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 in_last,
  output logic                 out_vld,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_last
);

  logic [DEPTH-1:0]                vld_sr;
  logic [DEPTH-1:0]                last_sr;
  logic [DEPTH-1:0][TAG_WIDTH-1:0] tag_sr;

  // NOTE: every stage is cleared, not just the valid bits, so reads in flight at
  // reset vanish and the tail tag reads back as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_sr  <= '0;
      last_sr <= '0;
      tag_sr  <= '0;
    end else begin
      vld_sr  <= {vld_sr[DEPTH-2:0], in_vld};
      last_sr <= {last_sr[DEPTH-2:0], in_last};
      tag_sr  <= {tag_sr[DEPTH-2:0], in_tag};
    end
  end

  assign out_vld  = vld_sr[DEPTH-1];
  assign out_tag  = tag_sr[DEPTH-1];
  assign out_last = last_sr[DEPTH-1];

endmodule

// File: rtl/qdrc_rd_pipe.sv
// QDR controller read-return path: strobe gating, burst tracking, tag delay line
// and outstanding-read count. Define QDRC_RD_OUTREG_EN to register the user outputs.
module qdrc_rd_pipe
  import qdrc_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int BURST_CYCLES = 1,
  parameter int PEND_WIDTH   = 6
) (
  input logic           clk,
  input logic           reset,
  qdrc_rd_pipe_if.slave bus
);

  localparam int CNT_W = cnt_width(BURST_CYCLES);

  logic [CNT_W-1:0]     burst_cnt;
  logic [TAG_WIDTH-1:0] held_tag;
  logic                 busy;
  logic                 accept;

  ins_sel_e             ins_sel;
  logic                 ins_vld;
  logic [TAG_WIDTH-1:0] ins_tag;
  logic                 ins_last;

  logic                 tail_vld;
  logic [TAG_WIDTH-1:0] tail_tag;
  logic                 tail_last;

  logic                 out_vld;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_last;

  logic [PEND_WIDTH-1:0] pend_q;

  assign busy         = (burst_cnt != '0);
  assign bus.usr_rdy  = bus.phy_rdy & ~busy & ~reset;
  assign accept       = bus.usr_strb & bus.usr_rdy;
  assign bus.phy_strb = accept;

  // Once loaded the counter runs down regardless of phy_rdy: a started burst is committed.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
      held_tag  <= '0;
    end else if (accept) begin
      burst_cnt <= CNT_W'(BURST_CYCLES - 1);
      held_tag  <= bus.usr_tag;
    end else if (busy) begin
      burst_cnt <= burst_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    ins_sel = INS_NONE;
    if (accept)    ins_sel = INS_ACCEPT;
    else if (busy) ins_sel = INS_BURST;
  end

  // NOTE: all outputs get a default before the case so no path leaves a latch behind.
  always_comb begin
    ins_vld  = 1'b0;
    ins_tag  = '0;
    ins_last = 1'b0;
    case (ins_sel)
      INS_ACCEPT: begin
        ins_vld  = 1'b1;
        ins_tag  = bus.usr_tag;
        ins_last = (BURST_CYCLES == 1);
      end
      INS_BURST: begin
        ins_vld  = 1'b1;
        ins_tag  = held_tag;
        ins_last = (burst_cnt == CNT_W'(1));
      end
      default: ;
    endcase
  end

  qdrc_rd_delay #(
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (READ_LATENCY)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (ins_vld),
    .in_tag   (ins_tag),
    .in_last  (ins_last),
    .out_vld  (tail_vld),
    .out_tag  (tail_tag),
    .out_last (tail_last)
  );

`ifdef QDRC_RD_OUTREG_EN
  logic [2*DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      out_vld  <= 1'b0;
      out_tag  <= '0;
      out_last <= 1'b0;
    end else begin
      data_q   <= bus.phy_data;
      out_vld  <= tail_vld;
      out_tag  <= tail_tag;
      out_last <= tail_last;
    end
  end

  assign bus.usr_data = data_q;
`else
  assign bus.usr_data = bus.phy_data;
  assign out_vld      = tail_vld;
  assign out_tag      = tail_tag;
  assign out_last     = tail_last;
`endif

  assign bus.usr_dvld  = out_vld;
  assign bus.usr_dtag  = out_tag;
  assign bus.usr_dlast = out_last;

  // A read completes when its last beat leaves the output stage actually seen by the user.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      case ({accept, out_vld & out_last})
        2'b10:   pend_q <= pend_q + PEND_WIDTH'(1);
        2'b01:   pend_q <= pend_q - PEND_WIDTH'(1);
        default: pend_q <= pend_q;
      endcase
    end
  end

  assign bus.rd_pending = pend_q;

endmodule

// File: tb/tb_qdrc_rd_pipe.sv
// Self-checking bench for qdrc_rd_pipe: one instance per burst length, checked by
// a directed vector table, corner-case sequences and a randomized reference model.
module tb_qdrc_rd_pipe;

  localparam int DW = 18;
  localparam int TW = 4;
  localparam int PW = 6;
  localparam int RL = 10;
`ifdef QDRC_RD_OUTREG_EN
  localparam int LAT  = RL + 1;
  localparam bit OREG = 1'b1;
`else
  localparam int LAT  = RL;
  localparam bit OREG = 1'b0;
`endif
  localparam int NV   = LAT + 6;
  localparam int RING = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  qdrc_rd_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .PEND_WIDTH(PW)) if0 ();
  qdrc_rd_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .PEND_WIDTH(PW)) if1 ();

  qdrc_rd_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .READ_LATENCY(RL),
                 .BURST_CYCLES(1), .PEND_WIDTH(PW))
    u_dut_b1 (.clk(clk), .reset(reset), .bus(if0));

  qdrc_rd_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .READ_LATENCY(RL),
                 .BURST_CYCLES(2), .PEND_WIDTH(PW))
    u_dut_b2 (.clk(clk), .reset(reset), .bus(if1));

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus for the next cycle, per instance.
  logic            drv_reset;
  logic            drv_rdy  [2];
  logic            drv_strb [2];
  logic [TW-1:0]   drv_tag  [2];
  logic [2*DW-1:0] drv_data [2];

  // Outputs observed in the last cycle.
  logic            obs_rdy  [2];
  logic            obs_strb [2];
  logic            obs_dvld [2];
  logic [TW-1:0]   obs_dtag [2];
  logic            obs_dlast[2];
  logic [PW-1:0]   obs_pend [2];
  logic [2*DW-1:0] obs_data [2];

  // Reference model: a ring of scheduled beats indexed by absolute cycle number.
  int              bc [2] = '{1, 2};
  int              cyc;
  int              next_free [2];
  int              pend [2];
  logic            s_vld  [2][RING];
  logic [TW-1:0]   s_tag  [2][RING];
  logic            s_last [2][RING];
  logic [2*DW-1:0] prev_data [2];

  typedef struct {
    logic          rdy;
    logic          strb;
    logic [TW-1:0] tag;
    logic          e_rdy;
    logic          e_strb;
    logic          e_dvld;
    logic [TW-1:0] e_dtag;
    logic          e_dlast;
    int            e_pend;
  } vec_t;

  vec_t vec [2][NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < RING; s++) begin
        s_vld[d][s]  = 1'b0;
        s_tag[d][s]  = '0;
        s_last[d][s] = 1'b0;
      end
      pend[d]      = 0;
      next_free[d] = cyc;
      prev_data[d] = '0;
    end
  endtask

  task automatic set_idle();
    for (int d = 0; d < 2; d++) begin
      drv_rdy[d]  = 1'b1;
      drv_strb[d] = 1'b0;
      drv_tag[d]  = '0;
    end
  endtask

  // One clock cycle: apply stimulus, sample outputs, compare against the model, advance.
  task automatic tick();
    logic          e_acc [2];
    logic          e_rdy;
    int            slot;
    logic [63:0]   r;
    for (int d = 0; d < 2; d++) begin
      r = {$urandom(), $urandom()};
      drv_data[d] = r[2*DW-1:0];
    end
    @(negedge clk);
    reset        = drv_reset;
    if0.phy_rdy  = drv_rdy[0];  if0.usr_strb = drv_strb[0];
    if0.usr_tag  = drv_tag[0];  if0.phy_data = drv_data[0];
    if1.phy_rdy  = drv_rdy[1];  if1.usr_strb = drv_strb[1];
    if1.usr_tag  = drv_tag[1];  if1.phy_data = drv_data[1];
    #1;
    obs_rdy[0]  = if0.usr_rdy;  obs_strb[0] = if0.phy_strb; obs_dvld[0] = if0.usr_dvld;
    obs_dtag[0] = if0.usr_dtag; obs_dlast[0] = if0.usr_dlast;
    obs_pend[0] = if0.rd_pending; obs_data[0] = if0.usr_data;
    obs_rdy[1]  = if1.usr_rdy;  obs_strb[1] = if1.phy_strb; obs_dvld[1] = if1.usr_dvld;
    obs_dtag[1] = if1.usr_dtag; obs_dlast[1] = if1.usr_dlast;
    obs_pend[1] = if1.rd_pending; obs_data[1] = if1.usr_data;

    if (drv_reset) model_clear();
    slot = cyc % RING;
    for (int d = 0; d < 2; d++) begin
      e_rdy    = !drv_reset && drv_rdy[d] && (cyc >= next_free[d]);
      e_acc[d] = e_rdy && drv_strb[d];
      check($sformatf("m%0d usr_rdy", d),    64'(obs_rdy[d]),   64'(e_rdy));
      check($sformatf("m%0d phy_strb", d),   64'(obs_strb[d]),  64'(e_acc[d]));
      check($sformatf("m%0d usr_dvld", d),   64'(obs_dvld[d]),  64'(s_vld[d][slot]));
      check($sformatf("m%0d usr_dtag", d),   64'(obs_dtag[d]),  64'(s_tag[d][slot]));
      check($sformatf("m%0d usr_dlast", d),  64'(obs_dlast[d]), 64'(s_last[d][slot]));
      check($sformatf("m%0d rd_pending", d), 64'(obs_pend[d]),  64'(pend[d]));
      check($sformatf("m%0d usr_data", d),   64'(obs_data[d]),
            OREG ? 64'(prev_data[d]) : 64'(drv_data[d]));
    end

    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!drv_reset) begin
        if (e_acc[d]) begin
          for (int k = 0; k < bc[d]; k++) begin
            s_vld[d][(cyc + LAT + k) % RING]  = 1'b1;
            s_tag[d][(cyc + LAT + k) % RING]  = drv_tag[d];
            s_last[d][(cyc + LAT + k) % RING] = (k == bc[d] - 1);
          end
          next_free[d] = cyc + bc[d];
          pend[d]++;
        end
        if (s_vld[d][slot] && s_last[d][slot]) pend[d]--;
        prev_data[d] = drv_data[d];
      end
      s_vld[d][slot]  = 1'b0;
      s_tag[d][slot]  = '0;
      s_last[d][slot] = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    cyc = 0;
    model_clear();
    set_idle();
    drv_reset = 1'b1;
    tick(); tick();
    drv_reset = 1'b0;
    tick(); tick();

    // Directed table: single read on the burst-2 instance and two bursts on the burst-4 one.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NV; i++)
        vec[d][i] = '{1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 0};
    vec[0][0].strb = 1'b1; vec[0][0].tag = 4'h5; vec[0][0].e_strb = 1'b1;
    vec[0][LAT].e_dvld = 1'b1; vec[0][LAT].e_dtag = 4'h5; vec[0][LAT].e_dlast = 1'b1;
    for (int i = 1; i <= LAT; i++) vec[0][i].e_pend = 1;
    vec[1][0].strb = 1'b1; vec[1][0].tag = 4'h1; vec[1][0].e_strb = 1'b1;
    vec[1][1].strb = 1'b1; vec[1][1].tag = 4'h9; vec[1][1].e_rdy  = 1'b0;
    vec[1][2].strb = 1'b1; vec[1][2].tag = 4'h2; vec[1][2].e_strb = 1'b1;
    vec[1][3].strb = 1'b1; vec[1][3].tag = 4'h2; vec[1][3].e_rdy  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec[1][LAT+k].e_dvld  = 1'b1;
      vec[1][LAT+k].e_dtag  = (k < 2) ? 4'h1 : 4'h2;
      vec[1][LAT+k].e_dlast = (k % 2 == 1);
    end
    for (int i = 1; i < NV; i++)
      vec[1][i].e_pend = (i <= 2) ? 1 : (i <= LAT + 1) ? 2 : (i <= LAT + 3) ? 1 : 0;

    for (int i = 0; i < NV; i++) begin
      for (int d = 0; d < 2; d++) begin
        drv_rdy[d] = vec[d][i].rdy; drv_strb[d] = vec[d][i].strb; drv_tag[d] = vec[d][i].tag;
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        check($sformatf("v%0d[%0d] usr_rdy", d, i),    64'(obs_rdy[d]),   64'(vec[d][i].e_rdy));
        check($sformatf("v%0d[%0d] phy_strb", d, i),   64'(obs_strb[d]),  64'(vec[d][i].e_strb));
        check($sformatf("v%0d[%0d] usr_dvld", d, i),   64'(obs_dvld[d]),  64'(vec[d][i].e_dvld));
        check($sformatf("v%0d[%0d] usr_dtag", d, i),   64'(obs_dtag[d]),  64'(vec[d][i].e_dtag));
        check($sformatf("v%0d[%0d] usr_dlast", d, i),  64'(obs_dlast[d]), 64'(vec[d][i].e_dlast));
        check($sformatf("v%0d[%0d] rd_pending", d, i), 64'(obs_pend[d]),  64'(vec[d][i].e_pend));
      end
    end
    set_idle();
    for (int i = 0; i < 4; i++) tick();

    // PHY not ready with strobe held: every request is dropped.
    cnt = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      for (int d = 0; d < 2; d++) begin
        drv_rdy[d] = 1'b0; drv_strb[d] = 1'b1; drv_tag[d] = 4'hA;
      end
      tick();
      cnt += int'(obs_strb[0]) + int'(obs_strb[1]) + int'(obs_dvld[0]) + int'(obs_dvld[1]);
    end
    check("no_rdy strobes_and_beats", 64'(cnt), 64'd0);
    check("no_rdy rd_pending", 64'(obs_pend[1]), 64'd0);

    // phy_rdy drops right after a burst-4 accept: both beats still return.
    set_idle();
    drv_strb[1] = 1'b1; drv_tag[1] = 4'h6;
    tick();
    cnt = 0;
    drv_strb[1] = 1'b0; drv_rdy[1] = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      cnt += int'(obs_dvld[1]);
    end
    check("midburst beats_returned", 64'(cnt), 64'd2);
    set_idle();
    for (int i = 0; i < 3; i++) tick();

    // Reset five cycles after an accept discards the read in flight.
    drv_strb[0] = 1'b1; drv_tag[0] = 4'h7;
    drv_strb[1] = 1'b1; drv_tag[1] = 4'h7;
    tick();
    set_idle();
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset rd_pending", 64'(obs_pend[0]), 64'd1);
    drv_reset = 1'b1;
    tick();
    check("in_reset usr_rdy", 64'(obs_rdy[1]), 64'd0);
    check("in_reset rd_pending", 64'(obs_pend[1]), 64'd0);
    drv_reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      cnt += int'(obs_dvld[0]) + int'(obs_dvld[1]);
    end
    check("post_reset no_beats", 64'(cnt), 64'd0);

    // Accept coinciding with a last beat while three reads are pending.
    for (int i = 0; i <= LAT + 1; i++) begin
      set_idle();
      if (i < 3 || i == LAT) begin
        drv_strb[0] = 1'b1; drv_tag[0] = TW'(i + 1);
      end
      tick();
      if (i == LAT) begin
        check("coincide accept_and_last", 64'(obs_strb[0] & obs_dvld[0] & obs_dlast[0]), 64'd1);
        check("coincide pending_before", 64'(obs_pend[0]), 64'd3);
      end
      if (i == LAT + 1) check("coincide pending_after", 64'(obs_pend[0]), 64'd3);
    end
    set_idle();
    for (int i = 0; i < LAT + 4; i++) tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drv_reset = ($urandom_range(0, 199) == 0);
      for (int d = 0; d < 2; d++) begin
        drv_rdy[d]  = ($urandom_range(0, 7) != 0);
        drv_strb[d] = $urandom_range(0, 1) == 1;
        drv_tag[d]  = TW'($urandom());
      end
      tick();
    end
    drv_reset = 1'b0;
    set_idle();
    for (int i = 0; i < LAT + 4; i++) tick();
    check("final rd_pending0", 64'(obs_pend[0]), 64'd0);
    check("final rd_pending1", 64'(obs_pend[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qdrc_rd_pipe.md
# qdrc_rd_pipe

Parametrised read-return path for the QDR controller. It sits between the user read port and the QDR PHY. It gates read strobes on PHY readiness and burst occupancy, and carries a user tag through a configurable-latency delay line. Returned PHY data is delivered with valid, tag and last-beat markers. A count of outstanding reads is kept for upstream flow control.

## Interface
Parameters:
- DATA_WIDTH, 18, QDR data width per edge; data buses are 2*DATA_WIDTH.
- TAG_WIDTH, 4, width of the user read tag.
- READ_LATENCY, 10, cycles from accepted strobe to first returned beat; legal range 2..32.
- BURST_CYCLES, 1, clk cycles of data per read (1 = burst-2, 2 = burst-4).
- PEND_WIDTH, 6, width of rd_pending; must hold READ_LATENCY+2.

Ports:
- clk  in  1  controller clock.
- reset  in  1  asynchronous, active-high reset.
- phy_rdy  in  1  PHY calibrated and able to accept reads.
- usr_strb  in  1  read request.
- usr_tag  in  TAG_WIDTH  tag sampled with an accepted usr_strb.
- usr_rdy  out  1  request will be accepted this cycle.
- usr_data  out  2*DATA_WIDTH  returned read data.
- usr_dvld  out  1  usr_data valid.
- usr_dtag  out  TAG_WIDTH  tag of the current returned beat.
- usr_dlast  out  1  final beat of a read.
- rd_pending  out  PEND_WIDTH  reads accepted but not yet completed.
- phy_strb  out  1  read strobe to PHY.
- phy_data  in  2*DATA_WIDTH  read data from PHY.

## Operation
- The accept condition is usr_strb & usr_rdy.
- usr_rdy = phy_rdy & ~busy & ~reset.
- phy_strb equals accept, combinationally. A usr_strb while usr_rdy is low is dropped silently, with no phy_strb.
- busy asserts for BURST_CYCLES-1 cycles after an accept, driven by a down-counter. With BURST_CYCLES=1, busy is never set.
- Once started, a burst is committed. If phy_rdy falls mid-burst, the burst still completes and its beats are still returned.
- Delay line: READ_LATENCY stages, each holding {vld, tag, last}. The line shifts every cycle and inserts one entry per cycle:
  - accept cycle: {1, usr_tag, BURST_CYCLES==1}.
  - each busy cycle: {1, held tag, busy counter reaching its final count}.
  - any other cycle: {0, 0, 0}.
- The tail of the delay line drives usr_dvld, usr_dtag and usr_dlast. usr_data is phy_data passed straight through.
- rd_pending increments on accept and decrements when usr_dvld & usr_dlast. Both in the same cycle leave it unchanged. It never wraps, because PEND_WIDTH covers the maximum in-flight count.
- Reset clears the delay line, the busy counter and rd_pending asynchronously. Reads in flight at reset are discarded; no usr_dvld is produced for them.
- Reset values: usr_rdy 0, usr_dvld 0, usr_dtag 0, usr_dlast 0, rd_pending 0, phy_strb 0. usr_data follows phy_data.

## Timing
- Accept at cycle T gives phy_strb high at T, combinationally.
- The first beat has usr_dvld high at T+READ_LATENCY. Beat k (0-based) appears at T+READ_LATENCY+k.
- Back-to-back accepts are allowed every BURST_CYCLES cycles, giving a gapless usr_dvld stream.
- rd_pending reflects an accept one cycle after it and a completion one cycle after the last beat.
- Deasserting reset makes usr_rdy follow phy_rdy in the same cycle. The first accept is possible on the first clk edge after reset release.

## Configuration
- QDRC_RD_OUTREG_EN defined:
  - usr_data, usr_dvld, usr_dtag and usr_dlast are registered one more cycle, so the first beat arrives at T+READ_LATENCY+1.
  - The registered usr_data resets to 0.
  - rd_pending decrements on the registered last beat.
- QDRC_RD_OUTREG_EN undefined: the output path behaves as described under Operation, with no extra register stage.

## Structure
- Shared package qdrc_pkg holds:
  - the default DATA_WIDTH and TAG_WIDTH;
  - the latency-component constants (sync, output register, output buffer, chip, input buffer, half-offset and word-offset correction);
  - the derived default READ_LATENCY.
- Sub-module qdrc_rd_delay is a parametrised shift register of {vld, tag, last}, READ_LATENCY deep, with asynchronous clear. The top level holds the strobe gating, the burst counter, the pending counter and the optional output register.

## Test plan
- READ_LATENCY=10, BURST_CYCLES=1. Single accept with tag 0x5 at T → phy_strb at T; usr_dvld, usr_dlast and usr_dtag=0x5 at T+10; rd_pending goes 0→1→0.
- BURST_CYCLES=2. Accepts with tags 0x1 and 0x2 at T and T+2 → usr_dvld high T+10..T+13; usr_dlast at T+11 and T+13; tags 1,1,2,2; usr_rdy low at T+1 and T+3.
- phy_rdy=0 with usr_strb held high → no phy_strb, no usr_dvld, rd_pending stays 0. phy_rdy falling mid-burst → the remaining beat is still returned.
- Reset asserted at T+5 after an accept at T → all outputs 0 immediately; no usr_dvld at T+10; rd_pending=0.
- Accept and last beat in the same cycle with rd_pending=3 → rd_pending stays 3.
- QDRC_RD_OUTREG_EN defined → first beat at T+11; usr_data is registered phy_data and is 0 during reset.
